seq_slice_comparator: RTL
=========================

Name: seq_slice_comparator

Overview:
- Parametrised, low-power successor to the team's 4-bit combinational magnitude comparator.
- Compares two WIDTH-bit operands one SLICE-bit slice per clock, MSB slice first, and stops at the first unequal slice.
- Adds a signed/unsigned mode, a valid/ready handshake on input and output, and a count of slices examined for power profiling.
- Sits between operand registers and any consumer of GT/LT/EQ flags.

Parameters:
- WIDTH, 16: operand width in bits; must be a multiple of SLICE and at least SLICE.
- SLICE, 4: bits compared per cycle. NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- a_gt_b  output  1  A > B.
- a_lt_b  output  1  A < B.
- a_eq_b  output  1  A == B.
- cmp_cycles  output  $clog2(NSLICE)+1  number of slices examined for this result (1..NSLICE).

Behaviour:
- Reset (asynchronous, active-high): state IDLE; out_valid, a_gt_b, a_lt_b, a_eq_b and cmp_cycles = 0; captured operands cleared. in_ready = 0 while rst is high.
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture a, b, signed_mode; set slice index to NSLICE-1; clear the slice counter; go to BUSY.
- State BUSY:
  - in_ready = 0. Each cycle, compare slice [idx*SLICE +: SLICE] of A and B as unsigned values, and increment the slice counter.
  - Signed mode: on the MSB slice only, invert bit WIDTH-1 of both operands before comparing. No other slice changes.
  - Slice unequal: latch gt or lt, then go to DONE.
  - Slice equal and idx == 0: latch eq, then go to DONE.
  - Otherwise: decrement idx and stay in BUSY.
- State DONE:
  - out_valid = 1. Flags and cmp_cycles are registered and stable.
  - Exactly one of gt/lt/eq is high.
  - Stays in DONE while out_ready = 0; on out_ready = 1 go to IDLE, clearing out_valid and all flags in the same edge.
  - in_ready = 0 in DONE, so there is no overlap of accept and deliver.
- Latency:
  - Operands accepted on edge t; BUSY examines slices on edges t+1 .. t+m; out_valid is high from edge t+m onward.
  - m = index of the first unequal slice counted from the MSB (1-based), or NSLICE if all slices are equal.
  - Minimum spacing between accepts is m+2 cycles.
- Flags are 0 whenever out_valid = 0.
- Reset mid-BUSY or mid-DONE: the operation is discarded with no output; after release, in_ready = 1 on the first cycle.
- in_valid asserted outside IDLE is ignored; the producer must hold in_valid until in_ready is seen.
- Operands on a and b may change freely after capture.
- Elaboration error if WIDTH % SLICE != 0 or SLICE < 1.

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN.
- Defined: early termination as described above; latency is data-dependent and cmp_cycles = m.
- Not defined: constant latency.
  - BUSY always examines all NSLICE slices.
  - The first unequal slice's decision is latched and later slices cannot change it.
  - DONE is entered after slice 0; cmp_cycles = NSLICE always.
  - Flag results are identical to the defined case.

Test Plan:
- WIDTH=16/SLICE=4, a=0x1234, b=0x1234, unsigned -> a_eq_b=1, gt=lt=0, cmp_cycles=4, out_valid 4 cycles after accept.
- a=0x8000, b=0x7FFF, unsigned -> a_gt_b=1, cmp_cycles=1 with CMP_EARLY_EXIT_EN, 4 without.
- Same operands, signed_mode=1 -> a_lt_b=1 (-32768 < 32767), same cmp_cycles as the previous test.
- a=0x12A4, b=0x12B4, unsigned -> a_lt_b=1, cmp_cycles=3 (early exit); signed a=0xFFFF, b=0x0001 -> a_lt_b=1, cmp_cycles=1.
- Back-pressure: result pending, out_ready=0 for 5 cycles, in_valid=1 with new operands -> flags and cmp_cycles stable, in_ready=0, nothing accepted; out_ready=1 -> IDLE next edge, then the new operands are accepted.
- Assert rst for 1 cycle in the second BUSY cycle -> out_valid never rises for that operation, all flags 0, in_ready=1 on the first cycle after release; the next compare 0x0001 vs 0x0000 gives a_gt_b=1, cmp_cycles=4.

Source files
------------

// File: rtl/seq_slice_comparator_if.sv
// Operand/result bus for seq_slice_comparator.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The source holds valid and its payload stable until that
// edge; ready may be low at any time and the source must not wait for ready
// before raising valid. Input side: in_valid/in_ready carry a, b, signed_mode.
// Output side: out_valid/out_ready carry a_gt_b, a_lt_b, a_eq_b, cmp_cycles.
interface seq_slice_comparator_if #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
);
    localparam int NSLICE = (SLICE > 0) ? WIDTH / SLICE : 1;
    localparam int CW     = $clog2(NSLICE) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;
    logic [CW-1:0]    cmp_cycles;

    // Producer/consumer side
    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, a_gt_b, a_lt_b, a_eq_b, cmp_cycles
    );

    // Comparator side
    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, a_gt_b, a_lt_b, a_eq_b, cmp_cycles
    );
endinterface

// File: rtl/seq_slice_comparator.sv
// Sequential slice-by-slice magnitude comparator.
// Compares two WIDTH-bit operands SLICE bits per clock, MSB slice first,
// with unsigned or two's-complement mode and a count of slices examined.
// Optional macro CMP_EARLY_EXIT_EN: stop at the first unequal slice.
// Without it every slice is walked (constant latency), the first unequal
// slice's decision is held, and cmp_cycles is always NSLICE.
// dbg_state exposes the FSM state (0 IDLE, 1 BUSY, 2 DONE).
module seq_slice_comparator #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_slice_comparator_if.slave  bus,
    output logic [1:0]             dbg_state
);
    localparam int NSLICE = (SLICE > 0) ? WIDTH / SLICE : 1;
    localparam int CW     = $clog2(NSLICE) + 1;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NSLICE - 1);

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    generate
        if (SLICE < 1) begin : g_bad_slice
            $error("seq_slice_comparator: SLICE must be at least 1");
        end else if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_width
            $error("seq_slice_comparator: WIDTH must be a nonzero multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             smode_q;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    cnt_q;
    logic             gt_q, lt_q, eq_q;
    // Decision from an earlier unequal slice (only used without early exit)
    logic             dec_q, dec_gt_q, dec_lt_q;

    logic [WIDTH-1:0] a_eff, b_eff;
    logic [SLICE-1:0] sa, sb;
    logic             slice_gt, slice_lt, slice_ne;
    logic             finish, accept;
    logic             fin_gt, fin_lt, fin_eq;

    // Current slice compare; signed mode flips the sign bit so the unsigned
    // slice compare orders two's-complement values correctly
    always_comb begin
        a_eff          = a_q;
        b_eff          = b_q;
        a_eff[WIDTH-1] = a_q[WIDTH-1] ^ smode_q;
        b_eff[WIDTH-1] = b_q[WIDTH-1] ^ smode_q;
        sa             = a_eff[idx_q*SLICE +: SLICE];
        sb             = b_eff[idx_q*SLICE +: SLICE];
        slice_gt       = sa > sb;
        slice_lt       = sa < sb;
        slice_ne       = sa != sb;
        finish         = (idx_q == '0) || (EARLY_EXIT && slice_ne);
        fin_gt         = dec_q ? dec_gt_q : slice_gt;
        fin_lt         = dec_q ? dec_lt_q : slice_lt;
        fin_eq         = !dec_q && !slice_ne;
        accept         = bus.in_valid && (state_q == IDLE) && !rst;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (finish) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and result outputs (Moore)
    always_comb begin
        bus.in_ready   = (state_q == IDLE) && !rst;
        bus.out_valid  = (state_q == DONE);
        bus.a_gt_b     = gt_q;
        bus.a_lt_b     = lt_q;
        bus.a_eq_b     = eq_q;
        bus.cmp_cycles = cnt_q;
        dbg_state      = state_q;
    end

    // Operand capture, slice walk and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            smode_q  <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            dec_q    <= 1'b0;
            dec_gt_q <= 1'b0;
            dec_lt_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        smode_q  <= bus.signed_mode;
                        idx_q    <= IDX_TOP;
                        cnt_q    <= '0;
                        dec_q    <= 1'b0;
                        dec_gt_q <= 1'b0;
                        dec_lt_q <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (finish) begin
                        gt_q <= fin_gt;
                        lt_q <= fin_lt;
                        eq_q <= fin_eq;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                        if (!dec_q && slice_ne) begin
                            dec_q    <= 1'b1;
                            dec_gt_q <= slice_gt;
                            dec_lt_q <= slice_lt;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        gt_q  <= 1'b0;
                        lt_q  <= 1'b0;
                        eq_q  <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
